// File: rtl/user_io_debounce_pkg.sv
// -----------------------------------------------------------------------------
// user_io_debounce_pkg
// Shared constants, types and parameter range checks for the user IO input
// conditioning block (synchronizer + debouncer + edge events).
//   USER_IO_N_CH      : user IO pin count. The IO pad stage uses the same value,
//                       so the two widths stay locked together.
//   DB_LIMIT_DEFAULT  : default number of consecutive differing samples needed
//                       before a new level is accepted.
//   ch_out_t          : per-channel debouncer result (level, rise, fall).
//   *_legal()         : range checks used for elaboration-time assertions.
// -----------------------------------------------------------------------------
package user_io_debounce_pkg;

    localparam int USER_IO_N_CH     = 20;
    localparam int DB_LIMIT_DEFAULT = 1000;
    localparam int SYNC_STAGES_MIN  = 2;
    localparam int SYNC_STAGES_MAX  = 4;

    typedef struct packed {
        logic level;
        logic rise;
        logic fall;
    } ch_out_t;

    function automatic bit sync_stages_legal(input int stages);
        return (stages >= SYNC_STAGES_MIN) && (stages <= SYNC_STAGES_MAX);
    endfunction

    // The limit must fit the counter: the highest count ever held is limit-1.
    function automatic bit db_limit_legal(input int limit, input int width);
        return (limit >= 1) && (longint'(limit) <= ((longint'(1) << width) - 1));
    endfunction

endpackage

// File: rtl/user_io_debounce_ch.sv
// -----------------------------------------------------------------------------
// user_io_debounce_ch
// One input channel: SYNC_STAGES-deep synchronizer, counter-based debouncer
// and one-cycle rise/fall pulse generation.
//   clk     : fabric clock
//   rst     : synchronous reset, active-high
//   pin_in  : raw pin level, asynchronous to clk
//   ch_out  : registered debounced level plus rise/fall pulses
// -----------------------------------------------------------------------------
module user_io_debounce_ch
    import user_io_debounce_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DB_WIDTH    = 16,
    parameter int DB_LIMIT    = DB_LIMIT_DEFAULT
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    pin_in,
    output ch_out_t ch_out
);

    localparam logic [DB_WIDTH-1:0] CNT_LAST = DB_WIDTH'(DB_LIMIT - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [DB_WIDTH-1:0]    cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   sync;

    assign sync = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], pin_in};
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (sync == level_q) begin
            // Back to the accepted level: discard any partial count so that
            // short glitches never accumulate.
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            level_d = sync;
            cnt_d   = '0;
            rise_d  = sync;
            fall_d  = ~sync;
        end else begin
            cnt_d = cnt_q + DB_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    always_comb begin
        ch_out       = '0;
        ch_out.level = level_q;
        ch_out.rise  = rise_q;
        ch_out.fall  = fall_q;
    end

endmodule

// File: rtl/user_io_debounce.sv
// -----------------------------------------------------------------------------
// user_io_debounce
// Conditions the user input pins coming out of the IO pad stage before fabric
// logic uses them: per-channel synchronizer/debouncer/edge pulses, sticky
// per-channel edge flags with write-one-to-clear, and one aggregate irq.
//   clk        : fabric clock
//   rst        : synchronous reset, active-high
//   pin_in     : raw pin levels (asynchronous)
//   evt_clr    : write-one-to-clear mask for evt_sticky, sampled every cycle
//   level_out  : debounced levels
//   rise_pulse : one-cycle pulse on an accepted 0->1 transition
//   fall_pulse : one-cycle pulse on an accepted 1->0 transition
//   evt_sticky : latched "edge seen" flag per channel
//   irq        : registered OR of evt_sticky
// -----------------------------------------------------------------------------
module user_io_debounce
    import user_io_debounce_pkg::*;
#(
    parameter int N_CH        = USER_IO_N_CH,
    parameter int SYNC_STAGES = 2,
    parameter int DB_WIDTH    = 16,
    parameter int DB_LIMIT    = DB_LIMIT_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] pin_in,
    input  logic [N_CH-1:0] evt_clr,
    output logic [N_CH-1:0] level_out,
    output logic [N_CH-1:0] rise_pulse,
    output logic [N_CH-1:0] fall_pulse,
    output logic [N_CH-1:0] evt_sticky,
    output logic            irq
);

    if (!sync_stages_legal(SYNC_STAGES)) begin : g_bad_sync_stages
        $error("user_io_debounce: SYNC_STAGES out of range 2..4");
    end
    if (!db_limit_legal(DB_LIMIT, DB_WIDTH)) begin : g_bad_db_limit
        $error("user_io_debounce: DB_LIMIT out of range 1..2^DB_WIDTH-1");
    end

    ch_out_t ch_out [N_CH];

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        user_io_debounce_ch #(
            .SYNC_STAGES (SYNC_STAGES),
            .DB_WIDTH    (DB_WIDTH),
            .DB_LIMIT    (DB_LIMIT)
        ) u_ch (
            .clk    (clk),
            .rst    (rst),
            .pin_in (pin_in[gi]),
            .ch_out (ch_out[gi])
        );
        assign level_out[gi]  = ch_out[gi].level;
        assign rise_pulse[gi] = ch_out[gi].rise;
        assign fall_pulse[gi] = ch_out[gi].fall;
    end

    logic [N_CH-1:0] evt_sticky_q, evt_sticky_d;
    logic            irq_q, irq_d;

    always_comb begin
        // New edges are OR'd in after the clear, so a same-cycle set wins.
        evt_sticky_d = (evt_sticky_q & ~evt_clr) | rise_pulse | fall_pulse;
        irq_d        = |evt_sticky_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            evt_sticky_q <= '0;
            irq_q        <= 1'b0;
        end else begin
            evt_sticky_q <= evt_sticky_d;
            irq_q        <= irq_d;
        end
    end

    assign evt_sticky = evt_sticky_q;
    assign irq        = irq_q;

endmodule

// File: tb/tb_user_io_debounce.sv
// -----------------------------------------------------------------------------
// tb_user_io_debounce
// Directed bench for user_io_debounce with DB_LIMIT=4, SYNC_STAGES=2.
// A table of per-cycle vectors covers the clean step, clear, glitch rejection
// and the exact-limit rise/fall; hand-written sequences cover bounce, the
// clear/set collision, reset mid-count and all channels at once.
// -----------------------------------------------------------------------------
module tb_user_io_debounce;
    import user_io_debounce_pkg::*;

    localparam int N   = 20;
    localparam int SS  = 2;
    localparam int DBL = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] pin_in;
    logic [N-1:0] evt_clr;
    logic [N-1:0] level_out, rise_pulse, fall_pulse, evt_sticky;
    logic         irq;

    always #5 clk = ~clk;

    user_io_debounce #(
        .N_CH        (N),
        .SYNC_STAGES (SS),
        .DB_WIDTH    (16),
        .DB_LIMIT    (DBL)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pin_in     (pin_in),
        .evt_clr    (evt_clr),
        .level_out  (level_out),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse),
        .evt_sticky (evt_sticky),
        .irq        (irq)
    );

    typedef struct {
        logic         rst;
        logic [N-1:0] pin;
        logic [N-1:0] clr;
        logic [N-1:0] level;
        logic [N-1:0] rise;
        logic [N-1:0] fall;
        logic [N-1:0] sticky;
        logic         irq;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_bad = 0;

    // Outputs are sampled 1 time unit after the active edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    function automatic vec_t mk(input logic [N-1:0] pin, input logic [N-1:0] clr,
                                input logic [N-1:0] level, input logic [N-1:0] rise,
                                input logic [N-1:0] fall, input logic [N-1:0] sticky,
                                input logic irq_e);
        vec_t v;
        v.rst = 1'b0; v.pin = pin; v.clr = clr; v.level = level;
        v.rise = rise; v.fall = fall; v.sticky = sticky; v.irq = irq_e;
        return v;
    endfunction

    task automatic do_reset;
        pin_in  = '0;
        evt_clr = '0;
        rst     = 1'b1;
        tick();
        tick();
        rst     = 1'b0;
    endtask

    // Ticks until rise_pulse[ch] is seen; n = ticks taken or -1 on timeout.
    task automatic wait_rise(input int ch, input int limit, output int n);
        n = -1;
        for (int k = 1; k <= limit; k++) begin
            tick();
            if (rise_pulse[ch]) begin
                n = k;
                break;
            end
        end
    endtask

    int   t, rise_t, n_rise, n_fall, nw;
    logic seq7 [6];

    initial begin
        pin_in  = '0;
        evt_clr = '0;
        rst     = 1'b1;
        do_reset();

        // ---------------- reset state ----------------
        check("reset.level",  level_out,  0);
        check("reset.rise",   rise_pulse, 0);
        check("reset.fall",   fall_pulse, 0);
        check("reset.sticky", evt_sticky, 0);
        check("reset.irq",    irq,        0);

        // ---------------- vector table ----------------
        // Clean step on ch3: level rises on the 6th edge, sticky one later,
        // irq one after that.
        for (int k = 0; k < 5; k++) vecs.push_back(mk(20'h8, 0, 20'h0, 0, 0, 0, 0));
        vecs.push_back(mk(20'h8, 0, 20'h8, 20'h8, 0, 0,     0));
        vecs.push_back(mk(20'h8, 0, 20'h8, 0,     0, 20'h8, 0));
        vecs.push_back(mk(20'h8, 0, 20'h8, 0,     0, 20'h8, 1));
        // Clear ch3: flag drops at once, irq one cycle later.
        vecs.push_back(mk(20'h8, 20'h8, 20'h8, 0, 0, 0, 1));
        vecs.push_back(mk(20'h8, 0,     20'h8, 0, 0, 0, 0));
        // ch0 high for 3 cycles: rejected.
        for (int k = 0; k < 3; k++) vecs.push_back(mk(20'h9, 0, 20'h8, 0, 0, 0, 0));
        for (int k = 0; k < 5; k++) vecs.push_back(mk(20'h8, 0, 20'h8, 0, 0, 0, 0));
        // ch0 high for exactly 4 cycles: accepted, then falls back.
        for (int k = 0; k < 4; k++) vecs.push_back(mk(20'h9, 0, 20'h8, 0, 0, 0, 0));
        vecs.push_back(mk(20'h8, 0, 20'h8, 0,     0,     0,     0));
        vecs.push_back(mk(20'h8, 0, 20'h9, 20'h1, 0,     0,     0));
        vecs.push_back(mk(20'h8, 0, 20'h9, 0,     0,     20'h1, 0));
        vecs.push_back(mk(20'h8, 0, 20'h9, 0,     0,     20'h1, 1));
        vecs.push_back(mk(20'h8, 0, 20'h9, 0,     0,     20'h1, 1));
        vecs.push_back(mk(20'h8, 0, 20'h8, 0,     20'h1, 20'h1, 1));
        vecs.push_back(mk(20'h8, 0, 20'h8, 0,     0,     20'h1, 1));

        foreach (vecs[i]) begin
            rst     = vecs[i].rst;
            pin_in  = vecs[i].pin;
            evt_clr = vecs[i].clr;
            tick();
            $display("vec %0d: pin=%h clr=%h -> level=%h rise=%h fall=%h sticky=%h irq=%0b",
                     i, pin_in, evt_clr, level_out, rise_pulse, fall_pulse, evt_sticky, irq);
            check($sformatf("vec%0d.level", i),  level_out,  vecs[i].level);
            check($sformatf("vec%0d.rise", i),   rise_pulse, vecs[i].rise);
            check($sformatf("vec%0d.fall", i),   fall_pulse, vecs[i].fall);
            check($sformatf("vec%0d.sticky", i), evt_sticky, vecs[i].sticky);
            check($sformatf("vec%0d.irq", i),    irq,        vecs[i].irq);
        end

        // ---------------- bounce then settle on ch7 ----------------
        do_reset();
        seq7 = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        t = 0; rise_t = -1; n_rise = 0; n_fall = 0;
        for (int k = 0; k < 22; k++) begin
            if (k < 6) pin_in[7] = seq7[k];
            tick();
            t++;
            if (rise_pulse[7]) begin
                n_rise++;
                if (rise_t < 0) rise_t = t;
            end
            if (fall_pulse[7]) n_fall++;
        end
        $display("bounce: rise at tick %0d, rises=%0d falls=%0d", rise_t, n_rise, n_fall);
        // Final stable 1 is captured on tick 6; accepted 5 edges later.
        check("bounce.rise_tick", rise_t, 11);
        check("bounce.n_rise",    n_rise, 1);
        check("bounce.n_fall",    n_fall, 0);
        check("bounce.level",     level_out[7], 1);

        // ---------------- clear vs set collision on ch5 ----------------
        do_reset();
        pin_in[5] = 1'b1;
        repeat (8) tick();
        check("coll.level_hi", level_out[5],  1);
        check("coll.sticky_hi", evt_sticky[5], 1);
        pin_in[5] = 1'b0;
        repeat (5) tick();
        check("coll.fall_early", fall_pulse[5], 0);
        tick();
        check("coll.fall", fall_pulse[5], 1);
        evt_clr[5] = 1'b1;
        tick();
        evt_clr[5] = 1'b0;
        $display("collision: sticky=%h irq=%0b", evt_sticky, irq);
        check("coll.set_wins", evt_sticky[5], 1);
        tick();
        check("coll.sticky_hold", evt_sticky[5], 1);
        check("coll.irq_hold",    irq, 1);
        evt_clr[5] = 1'b1;
        tick();
        evt_clr[5] = 1'b0;
        check("coll.cleared",  evt_sticky[5], 0);
        check("coll.irq_lag",  irq, 1);
        tick();
        check("coll.irq_drop", irq, 0);
        evt_clr[5] = 1'b1;
        tick();
        evt_clr[5] = 1'b0;
        check("coll.clr_idle", evt_sticky, 0);
        check("coll.irq_idle", irq, 0);

        // ---------------- reset mid-count on ch2 ----------------
        do_reset();
        pin_in[2] = 1'b1;
        repeat (4) tick();   // count is now 2
        check("rmid.level_pre", level_out[2], 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rmid.level",  level_out,  0);
        check("rmid.rise",   rise_pulse, 0);
        check("rmid.fall",   fall_pulse, 0);
        check("rmid.sticky", evt_sticky, 0);
        check("rmid.irq",    irq,        0);
        wait_rise(2, 20, nw);
        $display("reset mid-count: rise %0d edges after release", nw);
        check("rmid.latency", nw, SS + DBL);

        // ---------------- all channels at once ----------------
        do_reset();
        pin_in = 20'hFFFFF;
        repeat (5) tick();
        check("all.rise_early", rise_pulse, 0);
        tick();
        check("all.rise",  rise_pulse, 20'hFFFFF);
        check("all.level", level_out,  20'hFFFFF);
        tick();
        check("all.sticky", evt_sticky, 20'hFFFFF);
        check("all.irq_lag", irq, 0);
        tick();
        check("all.irq", irq, 1);
        evt_clr = 20'h0000F;
        tick();
        evt_clr = '0;
        check("all.partial_clr", evt_sticky, 20'hFFFF0);
        tick();
        $display("all channels: sticky=%h irq=%0b", evt_sticky, irq);
        check("all.sticky_keep", evt_sticky, 20'hFFFF0);
        check("all.irq_keep", irq, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    // Global time limit so the bench can never hang.
    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
